// File: rtl/exe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exe_pkg
// Description : ALU operation codes shared by the execute stage and its ALU.
// Revision    : 1.0
// ============================================================================
package exe_pkg;

    localparam int c_ALU_W = 6;

    localparam logic [c_ALU_W-1:0] c_ALU_NOP   = 6'h00;
    localparam logic [c_ALU_W-1:0] c_ALU_ADD   = 6'h01;
    localparam logic [c_ALU_W-1:0] c_ALU_SUB   = 6'h02;
    localparam logic [c_ALU_W-1:0] c_ALU_AND   = 6'h03;
    localparam logic [c_ALU_W-1:0] c_ALU_OR    = 6'h04;
    localparam logic [c_ALU_W-1:0] c_ALU_XOR   = 6'h05;
    localparam logic [c_ALU_W-1:0] c_ALU_NOR   = 6'h06;
    localparam logic [c_ALU_W-1:0] c_ALU_SLT   = 6'h07;
    localparam logic [c_ALU_W-1:0] c_ALU_SLTU  = 6'h08;
    localparam logic [c_ALU_W-1:0] c_ALU_SLL   = 6'h09;
    localparam logic [c_ALU_W-1:0] c_ALU_SRL   = 6'h0A;
    localparam logic [c_ALU_W-1:0] c_ALU_SRA   = 6'h0B;
    localparam logic [c_ALU_W-1:0] c_ALU_SLLV  = 6'h0C;
    localparam logic [c_ALU_W-1:0] c_ALU_SRLV  = 6'h0D;
    localparam logic [c_ALU_W-1:0] c_ALU_SRAV  = 6'h0E;
    localparam logic [c_ALU_W-1:0] c_ALU_LUI   = 6'h0F;
    localparam logic [c_ALU_W-1:0] c_ALU_PASSA = 6'h10;
    localparam logic [c_ALU_W-1:0] c_ALU_PASSB = 6'h11;
    localparam logic [c_ALU_W-1:0] c_ALU_MOVN  = 6'h12;
    localparam logic [c_ALU_W-1:0] c_ALU_MOVZ  = 6'h13;

endpackage
`default_nettype wire

// File: rtl/exe_alu.sv
`default_nettype none
// ============================================================================
// Module      : exe_alu
// Description : Combinational MIPS ALU; cond_ok gates the write for MOVN/MOVZ.
// Revision    : 1.0
// ============================================================================
module exe_alu
    import exe_pkg::*;
(
    input  logic [31:0]        a,
    input  logic [31:0]        b,
    input  logic [4:0]         shamt,
    input  logic [c_ALU_W-1:0] code,
    output logic [31:0]        result,
    output logic               cond_ok
);

    logic [4:0] w_var_sh;
    assign w_var_sh = a[4:0];

    always_comb begin
        result  = 32'h0;
        cond_ok = 1'b1;
        case (code)
            c_ALU_ADD:   result = a + b;
            c_ALU_SUB:   result = a - b;
            c_ALU_AND:   result = a & b;
            c_ALU_OR:    result = a | b;
            c_ALU_XOR:   result = a ^ b;
            c_ALU_NOR:   result = ~(a | b);
            c_ALU_SLT:   result = {31'h0, $signed(a) < $signed(b)};
            c_ALU_SLTU:  result = {31'h0, a < b};
            c_ALU_SLL:   result = b << shamt;
            c_ALU_SRL:   result = b >> shamt;
            c_ALU_SRA:   result = $unsigned($signed(b) >>> shamt);
            c_ALU_SLLV:  result = b << w_var_sh;
            c_ALU_SRLV:  result = b >> w_var_sh;
            c_ALU_SRAV:  result = $unsigned($signed(b) >>> w_var_sh);
            c_ALU_LUI:   result = {b[15:0], 16'h0};
            c_ALU_PASSA: result = a;
            c_ALU_PASSB: result = b;
            c_ALU_MOVN: begin
                result  = a;
                cond_ok = (b != 32'h0);
            end
            c_ALU_MOVZ: begin
                result  = a;
                cond_ok = (b == 32'h0);
            end
            default:     result = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/exe_stage.sv
`default_nettype none
// ============================================================================
// Module      : exe_stage
// Description : MIPS execute stage: MEM->EXE forwarding, ALU, EXE/MEM register.
// Revision    : 1.0
// ============================================================================
module exe_stage
    import exe_pkg::*;
#(
    parameter bit HAS_FORWARDING = 1'b1
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [31:0]        Instr1_IN,
    input  logic [31:0]        Instr1_PC_IN,
    input  logic               Request_Alt_PC,
    input  logic [31:0]        Alt_PC,
    input  logic [4:0]         RegisterA1_IN,
    input  logic [31:0]        OperandA1_IN,
    input  logic [4:0]         RegisterB1_IN,
    input  logic [31:0]        OperandB1_IN,
    input  logic [4:0]         WriteRegister1_IN,
    input  logic [31:0]        MemWriteData1_IN,
    input  logic               RegWrite1_IN,
    input  logic [c_ALU_W-1:0] ALU_Control1_IN,
    input  logic               MemRead1_IN,
    input  logic               MemWrite1_IN,
    input  logic [4:0]         ShiftAmount1_IN,
    input  logic [4:0]         BypassReg1_MEMEXE,
    input  logic [31:0]        BypassData1_MEMEXE,
    input  logic               BypassValid1_MEMEXE,
    output logic [31:0]        Instr1_OUT,
    output logic [31:0]        Instr1_PC_OUT,
    output logic [31:0]        ALU_result1_OUT,
    output logic [4:0]         WriteRegister1_OUT,
    output logic [31:0]        MemWriteData1_OUT,
    output logic               RegWrite1_OUT,
    output logic [c_ALU_W-1:0] ALU_Control1_OUT,
    output logic               MemRead1_OUT,
    output logic               MemWrite1_OUT,
    output logic [31:0]        Alt_PC1,
    output logic               Request_Alt_PC1,
    output logic [31:0]        ALU_result_async1,
    output logic               ALU_result_async_valid1
);

    logic        w_fwd_a;
    logic        w_fwd_b;
    logic        w_fwd_st;
    logic        w_async_en;
    logic [4:0]  w_rt;
    logic [31:0] w_op_a;
    logic [31:0] w_op_b;
    logic [31:0] w_store_data;
    logic [31:0] w_alu_result;
    logic        w_cond_ok;
    logic        w_eff_write;

    assign w_rt = Instr1_IN[20:16];

    // Register 0 is hard-wired, so a match on it must never forward.
    generate
        if (HAS_FORWARDING) begin : g_fwd
            assign w_fwd_a    = BypassValid1_MEMEXE && (RegisterA1_IN != 5'd0) &&
                                (BypassReg1_MEMEXE == RegisterA1_IN);
            assign w_fwd_b    = BypassValid1_MEMEXE && (RegisterB1_IN != 5'd0) &&
                                (BypassReg1_MEMEXE == RegisterB1_IN);
            assign w_fwd_st   = MemWrite1_IN && BypassValid1_MEMEXE && (w_rt != 5'd0) &&
                                (BypassReg1_MEMEXE == w_rt);
            assign w_async_en = 1'b1;
        end else begin : g_no_fwd
            assign w_fwd_a    = 1'b0;
            assign w_fwd_b    = 1'b0;
            assign w_fwd_st   = 1'b0;
            assign w_async_en = 1'b0;
        end
    endgenerate

    assign w_op_a       = w_fwd_a  ? BypassData1_MEMEXE : OperandA1_IN;
    assign w_op_b       = w_fwd_b  ? BypassData1_MEMEXE : OperandB1_IN;
    assign w_store_data = w_fwd_st ? BypassData1_MEMEXE : MemWriteData1_IN;

    exe_alu u_alu (
        .a       (w_op_a),
        .b       (w_op_b),
        .shamt   (ShiftAmount1_IN),
        .code    (ALU_Control1_IN),
        .result  (w_alu_result),
        .cond_ok (w_cond_ok)
    );

    assign w_eff_write = RegWrite1_IN && w_cond_ok;

    // Loads are excluded: their value only exists after the memory access.
    assign ALU_result_async1       = w_alu_result;
    assign ALU_result_async_valid1 = w_async_en && w_eff_write && !MemRead1_IN &&
                                     (WriteRegister1_IN != 5'd0);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            Instr1_OUT         <= 32'h0;
            Instr1_PC_OUT      <= 32'h0;
            ALU_result1_OUT    <= 32'h0;
            WriteRegister1_OUT <= 5'd0;
            MemWriteData1_OUT  <= 32'h0;
            RegWrite1_OUT      <= 1'b0;
            ALU_Control1_OUT   <= '0;
            MemRead1_OUT       <= 1'b0;
            MemWrite1_OUT      <= 1'b0;
            Alt_PC1            <= 32'h0;
            Request_Alt_PC1    <= 1'b0;
        end else begin
            Instr1_OUT         <= Instr1_IN;
            Instr1_PC_OUT      <= Instr1_PC_IN;
            ALU_result1_OUT    <= w_alu_result;
            WriteRegister1_OUT <= WriteRegister1_IN;
            MemWriteData1_OUT  <= w_store_data;
            RegWrite1_OUT      <= w_eff_write;
            ALU_Control1_OUT   <= ALU_Control1_IN;
            MemRead1_OUT       <= MemRead1_IN;
            MemWrite1_OUT      <= MemWrite1_IN;
            Alt_PC1            <= Alt_PC;
            Request_Alt_PC1    <= Request_Alt_PC;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exe_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_exe_stage
// Description : Table-driven scoreboard bench for exe_stage.
// Revision    : 1.0
// ============================================================================
module tb_exe_stage;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] Instr1_IN, Instr1_PC_IN, Alt_PC, OperandA1_IN, OperandB1_IN;
    logic [31:0] MemWriteData1_IN, BypassData1_MEMEXE;
    logic        Request_Alt_PC, RegWrite1_IN, MemRead1_IN, MemWrite1_IN, BypassValid1_MEMEXE;
    logic [4:0]  RegisterA1_IN, RegisterB1_IN, WriteRegister1_IN, ShiftAmount1_IN, BypassReg1_MEMEXE;
    logic [5:0]  ALU_Control1_IN;

    logic [31:0] Instr1_OUT, Instr1_PC_OUT, ALU_result1_OUT, MemWriteData1_OUT, Alt_PC1;
    logic [31:0] ALU_result_async1;
    logic [4:0]  WriteRegister1_OUT;
    logic [5:0]  ALU_Control1_OUT;
    logic        RegWrite1_OUT, MemRead1_OUT, MemWrite1_OUT, Request_Alt_PC1, ALU_result_async_valid1;

    exe_stage #(.HAS_FORWARDING(1'b1)) dut (
        .CLK(CLK), .RESET(RESET),
        .Instr1_IN(Instr1_IN), .Instr1_PC_IN(Instr1_PC_IN),
        .Request_Alt_PC(Request_Alt_PC), .Alt_PC(Alt_PC),
        .RegisterA1_IN(RegisterA1_IN), .OperandA1_IN(OperandA1_IN),
        .RegisterB1_IN(RegisterB1_IN), .OperandB1_IN(OperandB1_IN),
        .WriteRegister1_IN(WriteRegister1_IN), .MemWriteData1_IN(MemWriteData1_IN),
        .RegWrite1_IN(RegWrite1_IN), .ALU_Control1_IN(ALU_Control1_IN),
        .MemRead1_IN(MemRead1_IN), .MemWrite1_IN(MemWrite1_IN),
        .ShiftAmount1_IN(ShiftAmount1_IN),
        .BypassReg1_MEMEXE(BypassReg1_MEMEXE), .BypassData1_MEMEXE(BypassData1_MEMEXE),
        .BypassValid1_MEMEXE(BypassValid1_MEMEXE),
        .Instr1_OUT(Instr1_OUT), .Instr1_PC_OUT(Instr1_PC_OUT),
        .ALU_result1_OUT(ALU_result1_OUT), .WriteRegister1_OUT(WriteRegister1_OUT),
        .MemWriteData1_OUT(MemWriteData1_OUT), .RegWrite1_OUT(RegWrite1_OUT),
        .ALU_Control1_OUT(ALU_Control1_OUT), .MemRead1_OUT(MemRead1_OUT),
        .MemWrite1_OUT(MemWrite1_OUT), .Alt_PC1(Alt_PC1), .Request_Alt_PC1(Request_Alt_PC1),
        .ALU_result_async1(ALU_result_async1), .ALU_result_async_valid1(ALU_result_async_valid1)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr, pc, alt_pc, opa, opb, mwd, byp_data;
        logic        req_alt, rw, mr, mw, byp_valid;
        logic [4:0]  ra, rb, wr, sh, byp_reg;
        logic [5:0]  alu;
        logic [31:0] exp_res, exp_mwd;
        logic        exp_rw, exp_av;
    } vec_t;

    typedef struct {
        logic [31:0] instr, pc, res, mwd, alt_pc;
        logic [4:0]  wr;
        logic [5:0]  alu;
        logic        rw, mr, mw, req_alt;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[20];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] alu, input logic [4:0] ra, input logic [31:0] opa,
                                input logic [4:0] rb, input logic [31:0] opb, input logic [31:0] exp_res);
        vec_t v;
        v.instr = 32'h0; v.pc = 32'h0; v.alt_pc = 32'h0; v.req_alt = 1'b0;
        v.alu = alu; v.ra = ra; v.opa = opa; v.rb = rb; v.opb = opb; v.sh = 5'd0;
        v.wr = 5'd4; v.rw = 1'b1; v.mr = 1'b0; v.mw = 1'b0; v.mwd = 32'h1357_9BDF;
        v.byp_reg = 5'd0; v.byp_data = 32'h0; v.byp_valid = 1'b0;
        v.exp_res = exp_res; v.exp_rw = 1'b1; v.exp_av = 1'b1; v.exp_mwd = 32'h1357_9BDF;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        Instr1_IN = v.instr; Instr1_PC_IN = v.pc; Request_Alt_PC = v.req_alt; Alt_PC = v.alt_pc;
        RegisterA1_IN = v.ra; OperandA1_IN = v.opa; RegisterB1_IN = v.rb; OperandB1_IN = v.opb;
        WriteRegister1_IN = v.wr; MemWriteData1_IN = v.mwd; RegWrite1_IN = v.rw;
        ALU_Control1_IN = v.alu; MemRead1_IN = v.mr; MemWrite1_IN = v.mw; ShiftAmount1_IN = v.sh;
        BypassReg1_MEMEXE = v.byp_reg; BypassData1_MEMEXE = v.byp_data; BypassValid1_MEMEXE = v.byp_valid;
    endtask

    // Drive on the falling edge, check the async path, push the expectation,
    // then pop and compare the registered outputs just after the rising edge.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        @(negedge CLK);
        drive(v);
        #1;
        check({tag, ".async"}, ALU_result_async1, v.exp_res);
        check({tag, ".async_valid"}, {31'h0, ALU_result_async_valid1}, {31'h0, v.exp_av});
        e.instr = v.instr; e.pc = v.pc; e.res = v.exp_res; e.mwd = v.exp_mwd; e.alt_pc = v.alt_pc;
        e.wr = v.wr; e.alu = v.alu; e.rw = v.exp_rw; e.mr = v.mr; e.mw = v.mw; e.req_alt = v.req_alt;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        check({tag, ".result"}, ALU_result1_OUT, e.res);
        check({tag, ".regwrite"}, {31'h0, RegWrite1_OUT}, {31'h0, e.rw});
        check({tag, ".memwdata"}, MemWriteData1_OUT, e.mwd);
        check({tag, ".instr"}, Instr1_OUT, e.instr);
        check({tag, ".pc"}, Instr1_PC_OUT, e.pc);
        check({tag, ".wreg"}, {27'h0, WriteRegister1_OUT}, {27'h0, e.wr});
        check({tag, ".aluctl"}, {26'h0, ALU_Control1_OUT}, {26'h0, e.alu});
        check({tag, ".ctl"}, {29'h0, MemRead1_OUT, MemWrite1_OUT, Request_Alt_PC1},
              {29'h0, e.mr, e.mw, e.req_alt});
        check({tag, ".altpc"}, Alt_PC1, e.alt_pc);
    endtask

    initial begin
        vec_t v;
        tbl[0]  = mk(6'h01, 5'd1, 32'd5, 5'd2, 32'd7, 32'd12);
        tbl[1]  = mk(6'h01, 5'd3, 32'd1, 5'd0, 32'd1, 32'd101);
        tbl[1].byp_reg = 5'd3; tbl[1].byp_data = 32'd100; tbl[1].byp_valid = 1'b1;
        tbl[2]  = tbl[1]; tbl[2].byp_reg = 5'd0; tbl[2].exp_res = 32'd2;
        tbl[3]  = tbl[2]; tbl[3].ra = 5'd0;
        tbl[4]  = mk(6'h0B, 5'd0, 32'h0, 5'd0, 32'h8000_0000, 32'hF800_0000); tbl[4].sh = 5'd4;
        tbl[5]  = mk(6'h07, 5'd1, 32'hFFFF_FFFF, 5'd2, 32'd1, 32'd1);
        tbl[6]  = mk(6'h08, 5'd1, 32'hFFFF_FFFF, 5'd2, 32'd1, 32'd0);
        tbl[7]  = mk(6'h0F, 5'd0, 32'h0, 5'd0, 32'h1234, 32'h1234_0000);
        tbl[8]  = mk(6'h13, 5'd1, 32'h55, 5'd2, 32'd0, 32'h55); tbl[8].wr = 5'd5;
        tbl[9]  = mk(6'h13, 5'd1, 32'h55, 5'd2, 32'd3, 32'h55);
        tbl[9].exp_rw = 1'b0; tbl[9].exp_av = 1'b0;
        tbl[10] = mk(6'h01, 5'd1, 32'h1000, 5'd0, 32'd8, 32'h1008);
        tbl[10].mr = 1'b1; tbl[10].exp_av = 1'b0;
        tbl[11] = mk(6'h01, 5'd8, 32'h2000, 5'd0, 32'd4, 32'h2004);
        tbl[11].instr = 32'hAC09_0004; tbl[11].mw = 1'b1; tbl[11].rw = 1'b0; tbl[11].mwd = 32'h1111;
        tbl[11].byp_reg = 5'd9; tbl[11].byp_data = 32'hDEAD; tbl[11].byp_valid = 1'b1;
        tbl[11].exp_rw = 1'b0; tbl[11].exp_av = 1'b0; tbl[11].exp_mwd = 32'hDEAD;
        tbl[12] = mk(6'h02, 5'd1, 32'd10, 5'd2, 32'd3, 32'd7);
        tbl[13] = mk(6'h06, 5'd1, 32'h0, 5'd2, 32'h0, 32'hFFFF_FFFF);
        tbl[14] = mk(6'h0C, 5'd1, 32'd4, 5'd2, 32'd1, 32'd16);
        tbl[15] = mk(6'h3F, 5'd1, 32'd9, 5'd2, 32'd9, 32'd0); tbl[15].wr = 5'd6;
        tbl[16] = mk(6'h12, 5'd1, 32'd7, 5'd2, 32'd2, 32'd7);
        tbl[17] = mk(6'h01, 5'd1, 32'd1, 5'd2, 32'd1, 32'd2); tbl[17].wr = 5'd0; tbl[17].exp_av = 1'b0;
        tbl[18] = mk(6'h01, 5'd3, 32'd1, 5'd0, 32'd1, 32'd2);
        tbl[18].byp_reg = 5'd3; tbl[18].byp_data = 32'd100; tbl[18].byp_valid = 1'b0;
        tbl[19] = mk(6'h11, 5'd1, 32'd1, 5'd7, 32'd2, 32'd50);
        tbl[19].byp_reg = 5'd7; tbl[19].byp_data = 32'd50; tbl[19].byp_valid = 1'b1;

        // Reset with live inputs: registers clear, async result stays combinational.
        v = tbl[0]; v.instr = 32'hFFFF_FFFF; v.pc = 32'h1234; v.req_alt = 1'b1; v.alt_pc = 32'h99;
        v.mr = 1'b1; v.mw = 1'b1;
        RESET = 1'b1;
        drive(v);
        @(posedge CLK);
        #1;
        check("reset.result", ALU_result1_OUT, 32'h0);
        check("reset.regwrite", {31'h0, RegWrite1_OUT}, 32'h0);
        check("reset.instr", Instr1_OUT, 32'h0);
        check("reset.pc", Instr1_PC_OUT, 32'h0);
        check("reset.ctl", {29'h0, MemRead1_OUT, MemWrite1_OUT, Request_Alt_PC1}, 32'h0);
        check("reset.altpc", Alt_PC1, 32'h0);
        check("reset.memwdata", MemWriteData1_OUT, 32'h0);
        check("reset.async", ALU_result_async1, 32'd12);
        @(negedge CLK);
        RESET = 1'b0;

        for (int i = 0; i < 20; i++) begin
            v = tbl[i];
            if (v.instr == 32'h0) v.instr = 32'h1000_0000 + i;
            v.pc = 32'h0040_0000 + 4 * i;
            apply(v, $sformatf("vec%0d", i));
        end

        // Redirect must not appear before the capturing edge.
        v = tbl[0]; v.req_alt = 1'b1; v.alt_pc = 32'h400;
        @(negedge CLK);
        drive(v);
        #1;
        check("redirect.early_req", {31'h0, Request_Alt_PC1}, 32'h0);
        apply(v, "redirect");
        v.req_alt = 1'b0; v.alt_pc = 32'h0;
        apply(v, "redirect_clear");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage pipelined MIPS core; sits between the ID stage and the MEM stage.
- Takes decoded operands and control from ID and applies MEM-to-EXE operand forwarding.
- Computes the 6-bit-coded ALU result and registers the result plus all pass-through control into the EXE/MEM pipeline register.
- Also exports a combinational copy of the ALU result so ID can bypass from it.

Parameters:
- HAS_FORWARDING, default 1: 1 enables the MEM bypass inputs and the async result outputs. 0 ignores the bypass inputs and forces ALU_result_async_valid1=0.

Ports:
- CLK in 1: clock, rising edge.
- RESET in 1: synchronous, active-high reset.
- Instr1_IN in 32: instruction word.
- Instr1_PC_IN in 32: PC of the instruction.
- Request_Alt_PC in 1: redirect request from ID.
- Alt_PC in 32: redirect target from ID.
- RegisterA1_IN in 5: source register of operand A; 0 means none.
- OperandA1_IN in 32: operand A value.
- RegisterB1_IN in 5: source register of operand B; 0 when B is an immediate.
- OperandB1_IN in 32: operand B value.
- WriteRegister1_IN in 5: destination register.
- MemWriteData1_IN in 32: store data, which is the rt value.
- RegWrite1_IN in 1: instruction writes a register.
- ALU_Control1_IN in 6: ALU operation code.
- MemRead1_IN in 1: load.
- MemWrite1_IN in 1: store.
- ShiftAmount1_IN in 5: shamt field.
- BypassReg1_MEMEXE in 5: destination register of the instruction in MEM.
- BypassData1_MEMEXE in 32: write-back value from MEM.
- BypassValid1_MEMEXE in 1: MEM instruction writes a register.
- Instr1_OUT, Instr1_PC_OUT out 32: registered copies of the inputs.
- ALU_result1_OUT out 32: registered ALU result.
- WriteRegister1_OUT out 5: registered destination register.
- MemWriteData1_OUT out 32: registered, forwarded store data.
- RegWrite1_OUT out 1: registered effective write enable.
- ALU_Control1_OUT out 6: registered ALU operation code.
- MemRead1_OUT, MemWrite1_OUT out 1: registered memory controls.
- Alt_PC1 out 32, Request_Alt_PC1 out 1: registered redirect, passed on to MEM.
- ALU_result_async1 out 32: combinational ALU result.
- ALU_result_async_valid1 out 1: combinational, result is a bypassable register write.

Behaviour:
- One clock (CLK), rising edge; RESET is synchronous and active-high.
- Reset: every registered output is 0 on the first edge with RESET=1. The async outputs remain combinational during reset.
- Latency: 1 cycle. No stall or flush inputs; the register captures every cycle.
- Operand A selection: use BypassData1_MEMEXE when HAS_FORWARDING, BypassValid1_MEMEXE=1, RegisterA1_IN!=0 and BypassReg1_MEMEXE==RegisterA1_IN. Otherwise use OperandA1_IN.
- Operand B selection: same rule using RegisterB1_IN.
- Store data: MemWriteData is forwarded by the same rule, compared against rt = Instr1_IN[20:16], whenever MemWrite1_IN=1.
- Register 0 is never forwarded.
- ALU codes (A, B are the forwarded operands):
  - 0x00 NOP: result 0.
  - 0x01 ADD: A+B, wrapping, no overflow trap; also used for load/store addresses.
  - 0x02 SUB: A-B.
  - 0x03 AND, 0x04 OR, 0x05 XOR, 0x06 NOR.
  - 0x07 SLT: signed compare, result 1 or 0.
  - 0x08 SLTU: unsigned compare, result 1 or 0.
  - 0x09 SLL: B<<shamt. 0x0A SRL: B>>shamt, logical. 0x0B SRA: B>>shamt, arithmetic.
  - 0x0C SLLV, 0x0D SRLV, 0x0E SRAV: as above with the shift taken from A[4:0].
  - 0x0F LUI: {B[15:0],16'h0}.
  - 0x10 PASSA: result A. 0x11 PASSB: result B (link address for JAL).
  - 0x12 MOVN: result A; effective write = RegWrite1_IN && B!=0.
  - 0x13 MOVZ: result A; effective write = RegWrite1_IN && B==0.
  - Any other code: result 0, write enable passed through unchanged.
- RegWrite1_OUT is the registered effective write enable.
- ALU_result_async_valid1 = effective write && !MemRead1_IN && WriteRegister1_IN!=0. Load data is not yet known in EXE.
- Redirect and the remaining control/instruction fields are registered unchanged.

Decomposition:
- Package exe_pkg holds the ALU opcode localparams and their 6-bit width constant.
- One combinational sub-module, exe_alu, takes A, B, shamt and code, and returns the result and a cond_ok flag used for MOVN/MOVZ.
- Forwarding muxes and the pipeline register live in exe_stage.

Test Plan:
- Reset: RESET=1 for one edge -> all registered outputs 0. Deassert with ADD, A=5, B=7 -> next edge ALU_result1_OUT=12 and RegWrite1_OUT=1.
- Forwarding:
  - RegisterA1_IN=3, OperandA1_IN=1, Bypass reg 3, data 100, valid 1, ADD with B=1 -> result 101.
  - Same stimulus with Bypass reg 0 -> result 2.
  - RegisterA1_IN=0, Bypass reg 0, valid 1 -> no forwarding.
- Shifts and compares:
  - SRA: B=0x80000000, shamt 4 -> 0xF8000000.
  - SLT: A=-1, B=1 -> 1.
  - SLTU: A=-1, B=1 -> 0.
  - LUI: B=0x1234 -> 0x12340000.
- Conditional moves: MOVZ with B=0 -> RegWrite1_OUT=1 and async_valid=1. MOVZ with B=3 -> both 0.
- Load and async path: MemRead1_IN=1, ADD A=0x1000, B=8 -> ALU_result_async1=0x1008, async_valid=0, registered result 0x1008 and MemRead1_OUT=1.
- Store forwarding and redirect:
  - Store with rt=9 and bypass reg 9, data 0xDEAD -> MemWriteData1_OUT=0xDEAD.
  - Request_Alt_PC=1, Alt_PC=0x400 -> Alt_PC1 and Request_Alt_PC1 appear one cycle later.
